// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encoding,
// status/enable/pending bit positions and the misa value.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;  // MPP occupies [12:11]
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MEIP     = 11;

  // MXL in the top two bits plus the base integer ISA ('I', bit 8).
  function automatic logic [63:0] misa_value(input int xlen);
    return (xlen == 32) ? 64'h0000_0000_4000_0100 : 64'h8000_0000_0000_0100;
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR file bus: decode-side CSR access, trap controller inputs, and the
// vector/mepc/interrupt outputs consumed by fetch.
interface csr_if #(parameter int XLEN = 32);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic            mret;
  logic            instret_inc;
  logic            irq_ext;
  logic            irq_pending;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] mepc_out;

  modport master (
    output csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret, instret_inc, irq_ext,
    input  csr_rdata, csr_illegal, irq_pending, trap_vector, mepc_out
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret, instret_inc, irq_ext,
    output csr_rdata, csr_illegal, irq_pending, trap_vector, mepc_out
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter. Any write in a cycle suppresses that cycle's
// increment; a half write leaves the other half holding.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic        i_we_full,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_count
);
  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_we_full) begin
      r_count <= i_wdata;
    end else if (i_we_lo || i_we_hi) begin
      if (i_we_lo) r_count[31:0]  <= i_wdata[31:0];
      if (i_we_hi) r_count[63:32] <= i_wdata[63:32];
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with RMW ops, trap entry/mret, vectored mtvec and
// external interrupt gating. Define CSR_COUNTERS_EN for mcycle/minstret.
module csr_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 'h1800,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input logic   clk,
  input logic   rst,
  csr_if.slave  bus
);
  import csr_pkg::*;

  logic            r_mie, r_mpie, r_meie, r_meip;
  logic [1:0]      r_mpp;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;

  logic [XLEN-1:0] w_mstatus, w_rdata, w_wval, w_base;
  logic            w_impl, w_ro, w_illegal, w_wr;
  csr_op_e         w_op;

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;
`endif

  assign w_op = csr_op_e'(bus.csr_op);

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MIE]              = r_mie;
    w_mstatus[MSTATUS_MPIE]             = r_mpie;
    w_mstatus[MSTATUS_MPP+1:MSTATUS_MPP] = r_mpp;
  end

  // Read mux doubles as the address decoder for legality.
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    w_ro    = 1'b0;
    case (bus.csr_addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MISA:     w_rdata = XLEN'(misa_value(XLEN));
      CSR_MIE:      w_rdata[MIE_MEIE] = r_meie;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MIP:      w_rdata[MIP_MEIP] = r_meip;
      CSR_MHARTID: begin
        w_rdata = HART_ID;
        w_ro    = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   w_rdata = XLEN'(w_mcycle);
      CSR_MINSTRET: w_rdata = XLEN'(w_minstret);
      CSR_MCYCLEH: begin
        if (XLEN == 32) w_rdata = XLEN'(w_mcycle[63:32]);
        else            w_impl  = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) w_rdata = XLEN'(w_minstret[63:32]);
        else            w_impl  = 1'b0;
      end
`endif
      default:      w_impl = 1'b0;
    endcase
  end

  assign w_illegal = (w_op != CSR_NONE) && (!w_impl || w_ro);
  // Traps and mret pre-empt any CSR op issued in the same cycle.
  assign w_wr = (w_op != CSR_NONE) && !w_illegal && !bus.trap_valid && !bus.mret;

  always_comb begin
    case (w_op)
      CSR_WRITE: w_wval = bus.csr_wdata;
      CSR_SET:   w_wval = w_rdata | bus.csr_wdata;
      CSR_CLEAR: w_wval = w_rdata & ~bus.csr_wdata;
      default:   w_wval = w_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= MSTATUS_RST[MSTATUS_MIE];
      r_mpie     <= MSTATUS_RST[MSTATUS_MPIE];
      r_mpp      <= MSTATUS_RST[MSTATUS_MPP+1:MSTATUS_MPP];
      r_meie     <= 1'b0;
      r_meip     <= 1'b0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      r_meip <= bus.irq_ext;
      if (bus.trap_valid) begin
        r_mepc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
        r_mcause <= bus.trap_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mpp    <= 2'b11;
      end else if (bus.mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
        r_mpp  <= 2'b11;
      end else if (w_wr) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_wval[MSTATUS_MIE];
            r_mpie <= w_wval[MSTATUS_MPIE];
            r_mpp  <= w_wval[MSTATUS_MPP+1:MSTATUS_MPP];
          end
          CSR_MIE:      r_meie     <= w_wval[MIE_MEIE];
          CSR_MTVEC:    r_mtvec    <= w_wval;
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wval;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  localparam bit SPLIT = (XLEN == 32);
  logic [63:0] w_cnt_wdata;

  // Half writes present the value on both halves; the enables pick one.
  assign w_cnt_wdata = SPLIT ? {2{w_wval[31:0]}} : 64'(w_wval);

  csr_counter64 u_mcycle (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (1'b1),
    .i_we_lo   (SPLIT && w_wr && bus.csr_addr == CSR_MCYCLE),
    .i_we_hi   (SPLIT && w_wr && bus.csr_addr == CSR_MCYCLEH),
    .i_we_full (!SPLIT && w_wr && bus.csr_addr == CSR_MCYCLE),
    .i_wdata   (w_cnt_wdata),
    .o_count   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (bus.instret_inc),
    .i_we_lo   (SPLIT && w_wr && bus.csr_addr == CSR_MINSTRET),
    .i_we_hi   (SPLIT && w_wr && bus.csr_addr == CSR_MINSTRETH),
    .i_we_full (!SPLIT && w_wr && bus.csr_addr == CSR_MINSTRET),
    .i_wdata   (w_cnt_wdata),
    .o_count   (w_minstret)
  );
`else
  logic w_unused_inc;
  assign w_unused_inc = bus.instret_inc;
`endif

  assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    bus.trap_vector = w_base;
    if (r_mtvec[1:0] == 2'b01 && bus.trap_cause[XLEN-1])
      bus.trap_vector = w_base + {bus.trap_cause[XLEN-3:0], 2'b00};
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.csr_illegal = w_illegal;
  assign bus.irq_pending = r_mie & r_meie & r_meip;
  assign bus.mepc_out    = r_mepc;
endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized
// traffic against a mask/arithmetic reference model of the CSR file.
module tb_csr_unit;
  localparam int XLEN = 32;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_if #(.XLEN(XLEN)) bus();
  csr_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: mstatus kept as a full word masked to its live bits.
  logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
      12'h344, 12'hF14: return 1'b1;
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return CNT;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] op);
    return (op != 2'd0) && (!m_impl(a) || a == 12'hF14);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (!m_impl(a)) return 32'h0;
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_vec(input logic [31:0] cause);
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * cause[30:0];
    return base;
  endfunction

  always @(posedge clk) begin
    logic [31:0] old, nv;
    bit eff, cw, iw;
    if (rst) begin
      m_mstatus = 32'h1800; m_mie = 0; m_mip = 0; m_mtvec = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
    end else begin
      old = m_read(bus.csr_addr);
      eff = bus.csr_op != 2'd0 && !m_illegal(bus.csr_addr, bus.csr_op) &&
            !bus.trap_valid && !bus.mret;
      case (bus.csr_op)
        2'd1:    nv = bus.csr_wdata;
        2'd2:    nv = old | bus.csr_wdata;
        default: nv = old & ~bus.csr_wdata;
      endcase
      cw = eff && (bus.csr_addr == 12'hB00 || bus.csr_addr == 12'hB80);
      iw = eff && (bus.csr_addr == 12'hB02 || bus.csr_addr == 12'hB82);
      if (bus.trap_valid) begin
        m_mepc    = bus.trap_pc & ~32'h3;
        m_mcause  = bus.trap_cause;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (bus.mret) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (eff) begin
        case (bus.csr_addr)
          12'h300: m_mstatus  = nv & 32'h1888;
          12'h304: m_mie      = nv & 32'h800;
          12'h305: m_mtvec    = nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'hB00: m_cyc[31:0]  = nv;
          12'hB80: m_cyc[63:32] = nv;
          12'hB02: m_ins[31:0]  = nv;
          12'hB82: m_ins[63:32] = nv;
          default: ;
        endcase
      end
      if (!cw) m_cyc = m_cyc + 64'd1;
      if (!iw && bus.instret_inc) m_ins = m_ins + 64'd1;
      m_mip = bus.irq_ext ? 32'h800 : 32'h0;
    end
  end

  task automatic idle();
    bus.csr_addr = 12'h0; bus.csr_op = 2'd0; bus.csr_wdata = 0;
    bus.trap_valid = 0; bus.trap_pc = 0; bus.trap_cause = 0;
    bus.mret = 0; bus.instret_inc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
    bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = w;
    tick();
    bus.csr_op = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.irq_ext = 1'b0; idle();
    tick(); tick();
    rst = 1'b0;
    bus.csr_addr = 12'h300; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h1800) begin n_err++; $display("FAIL rst_mstatus got %h exp %h", bus.csr_rdata, 32'h1800); end
    bus.csr_addr = 12'h305; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mtvec got %h exp 0", bus.csr_rdata); end
    bus.csr_addr = 12'hF14; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_err++; $display("FAIL rst_nop_illegal got %b exp 0", bus.csr_illegal); end
    n_cmp++; if (bus.irq_pending !== 1'b0 || bus.mepc_out !== 32'h0) begin n_err++; $display("FAIL rst_outs got irq=%b mepc=%h exp 0/0", bus.irq_pending, bus.mepc_out); end
  endtask

  task automatic test_vector();
    csr(12'h305, 2'd1, 32'h8000_0001);
    bus.trap_valid = 1; bus.trap_pc = 32'h100; bus.trap_cause = 32'h8000_000B; #1;
    n_cmp++; if (bus.trap_vector !== 32'h8000_002C) begin n_err++; $display("FAIL vec_irq got %h exp %h", bus.trap_vector, 32'h8000_002C); end
    bus.trap_cause = 32'h2; #1;
    n_cmp++; if (bus.trap_vector !== 32'h8000_0000) begin n_err++; $display("FAIL vec_exc got %h exp %h", bus.trap_vector, 32'h8000_0000); end
    tick(); idle();
    csr(12'h305, 2'd1, 32'h8000_0100);
    bus.trap_cause = 32'h8000_0003; #1;
    n_cmp++; if (bus.trap_vector !== 32'h8000_0100) begin n_err++; $display("FAIL vec_direct got %h exp %h", bus.trap_vector, 32'h8000_0100); end
    csr(12'h305, 2'd1, 32'h8000_0102); #1;
    n_cmp++; if (bus.trap_vector !== 32'h8000_0100) begin n_err++; $display("FAIL vec_mode2 got %h exp %h", bus.trap_vector, 32'h8000_0100); end
    idle();
  endtask

  task automatic test_trap_mret();
    csr(12'h300, 2'd2, 32'h8);
    bus.trap_valid = 1; bus.trap_pc = 32'h8000_0102; bus.trap_cause = 32'h5;
    tick(); idle();
    bus.csr_addr = 12'h300; #1;
    n_cmp++; if (bus.mepc_out !== 32'h8000_0100) begin n_err++; $display("FAIL trap_mepc got %h exp %h", bus.mepc_out, 32'h8000_0100); end
    n_cmp++; if (bus.csr_rdata !== 32'h1880) begin n_err++; $display("FAIL trap_mstatus got %h exp %h", bus.csr_rdata, 32'h1880); end
    bus.csr_addr = 12'h342; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h5) begin n_err++; $display("FAIL trap_mcause got %h exp 5", bus.csr_rdata); end
    bus.mret = 1; tick(); idle();
    bus.csr_addr = 12'h300; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus got %h exp %h", bus.csr_rdata, 32'h1888); end
  endtask

  task automatic test_irq();
    csr(12'h304, 2'd2, 32'h800);
    bus.irq_ext = 1'b1; #1;
    n_cmp++; if (bus.irq_pending !== 1'b0) begin n_err++; $display("FAIL irq_early got %b exp 0", bus.irq_pending); end
    tick();
    n_cmp++; if (bus.irq_pending !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b exp 1", bus.irq_pending); end
    bus.csr_addr = 12'h344; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h800) begin n_err++; $display("FAIL mip_read got %h exp 800", bus.csr_rdata); end
    csr(12'h304, 2'd3, 32'h800); #1;
    n_cmp++; if (bus.irq_pending !== 1'b0) begin n_err++; $display("FAIL irq_masked got %b exp 0", bus.irq_pending); end
    bus.irq_ext = 1'b0; tick(); idle();
  endtask

  task automatic test_priority();
    csr(12'h340, 2'd1, 32'h1234);
    bus.csr_addr = 12'h340; bus.csr_op = 2'd1; bus.csr_wdata = 32'h55;
    bus.trap_valid = 1; bus.trap_pc = 32'h40; bus.trap_cause = 32'h7;
    tick(); idle();
    bus.csr_addr = 12'h340; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h1234) begin n_err++; $display("FAIL prio_trap_scratch got %h exp %h", bus.csr_rdata, 32'h1234); end
    n_cmp++; if (bus.mepc_out !== 32'h40) begin n_err++; $display("FAIL prio_trap_mepc got %h exp 40", bus.mepc_out); end
    bus.csr_op = 2'd1; bus.csr_wdata = 32'h99; bus.mret = 1;
    tick(); idle();
    bus.csr_addr = 12'h340; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h1234) begin n_err++; $display("FAIL prio_mret_scratch got %h exp %h", bus.csr_rdata, 32'h1234); end
    bus.csr_addr = 12'hF14; bus.csr_op = 2'd1; bus.csr_wdata = 32'hFF; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL hartid_wr got ill=%b rd=%h exp 1/0", bus.csr_illegal, bus.csr_rdata); end
    bus.csr_op = 2'd2; bus.csr_wdata = 32'h0; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL hartid_set0 got %b exp 1", bus.csr_illegal); end
    bus.csr_addr = 12'h301; bus.csr_op = 2'd1; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b0 || bus.csr_rdata !== 32'h4000_0100) begin n_err++; $display("FAIL misa_wr got ill=%b rd=%h exp 0/40000100", bus.csr_illegal, bus.csr_rdata); end
    bus.csr_addr = 12'h7C0; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL unimpl_wr got %b exp 1", bus.csr_illegal); end
    bus.csr_addr = 12'h344; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_err++; $display("FAIL mip_wr got %b exp 0", bus.csr_illegal); end
    idle();
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    csr(12'hB80, 2'd1, 32'h0);
    csr(12'hB00, 2'd1, 32'hFFFF_FFFF);
    bus.csr_addr = 12'hB00; #1;
    n_cmp++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cyc_wr got %h exp ffffffff", bus.csr_rdata); end
    tick();
    bus.csr_addr = 12'hB80; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_err++; $display("FAIL cyc_carry_hi got %h exp 1", bus.csr_rdata); end
    bus.csr_addr = 12'hB00; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL cyc_carry_lo got %h exp 0", bus.csr_rdata); end
    csr(12'hB00, 2'd1, 32'h5); #1;
    n_cmp++; if (bus.csr_rdata !== 32'h5) begin n_err++; $display("FAIL cyc_override got %h exp 5", bus.csr_rdata); end
    tick();
    n_cmp++; if (bus.csr_rdata !== 32'h6) begin n_err++; $display("FAIL cyc_resume got %h exp 6", bus.csr_rdata); end
    csr(12'hB82, 2'd1, 32'hFFFF_FFFF);
    bus.instret_inc = 1'b1;
    csr(12'hB02, 2'd1, 32'hFFFF_FFFF); #1;
    n_cmp++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ins_override got %h exp ffffffff", bus.csr_rdata); end
    tick(); bus.instret_inc = 1'b0;
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL ins_wrap_lo got %h exp 0", bus.csr_rdata); end
    bus.csr_addr = 12'hB82; #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL ins_wrap_hi got %h exp 0", bus.csr_rdata); end
`else
    bus.csr_addr = 12'hB00; bus.csr_op = 2'd1; bus.csr_wdata = 32'h5; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL cnt_absent got ill=%b rd=%h exp 1/0", bus.csr_illegal, bus.csr_rdata); end
    bus.csr_addr = 12'hB82; bus.csr_op = 2'd0; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b0 || bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL cnt_absent_rd got ill=%b rd=%h exp 0/0", bus.csr_illegal, bus.csr_rdata); end
`endif
    idle();
  endtask

  task automatic test_random();
    logic [11:0] addrs [15];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
              12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h000};
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      bus.csr_addr    = addrs[$urandom_range(0, 14)];
      bus.csr_op      = 2'($urandom_range(0, 3));
      bus.csr_wdata   = $urandom;
      bus.trap_valid  = ($urandom_range(0, 7) == 0);
      bus.trap_pc     = $urandom;
      bus.trap_cause  = {1'($urandom_range(0, 1)), 26'h0, 5'($urandom)};
      bus.mret        = ($urandom_range(0, 7) == 0);
      bus.instret_inc = 1'($urandom_range(0, 1));
      bus.irq_ext     = ($urandom_range(0, 2) == 0);
      #1;
      n_cmp++; if (bus.csr_rdata !== m_read(bus.csr_addr)) begin n_err++; $display("FAIL rnd_rdata[%0d] addr %h got %h exp %h", i, bus.csr_addr, bus.csr_rdata, m_read(bus.csr_addr)); end
      n_cmp++; if (bus.csr_illegal !== m_illegal(bus.csr_addr, bus.csr_op)) begin n_err++; $display("FAIL rnd_illegal[%0d] got %b exp %b", i, bus.csr_illegal, m_illegal(bus.csr_addr, bus.csr_op)); end
      n_cmp++; if (bus.trap_vector !== m_vec(bus.trap_cause)) begin n_err++; $display("FAIL rnd_vector[%0d] got %h exp %h", i, bus.trap_vector, m_vec(bus.trap_cause)); end
      n_cmp++; if (bus.irq_pending !== (m_mstatus[3] & m_mie[11] & m_mip[11])) begin n_err++; $display("FAIL rnd_irq[%0d] got %b exp %b", i, bus.irq_pending, m_mstatus[3] & m_mie[11] & m_mip[11]); end
      n_cmp++; if (bus.mepc_out !== m_mepc) begin n_err++; $display("FAIL rnd_mepc[%0d] got %h exp %h", i, bus.mepc_out, m_mepc); end
      tick();
    end
    rst = 1'b0; idle(); bus.irq_ext = 1'b0;
  endtask

  initial begin
    idle(); bus.irq_ext = 1'b0;
    test_reset();
    test_vector();
    test_trap_mret();
    test_irq();
    test_priority();
    test_counters();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Parameterised machine-mode CSR file, successor to the minimal mtvec/mepc/mstatus/mcause store.
- Adds read-modify-write CSR ops, full trap entry/exit semantics on mstatus, vectored mtvec, interrupt enable/pending logic and free-running 64-bit counters.
- Sits beside the execute stage.
- Decode drives the CSR ops; the trap controller drives trap/mret; the fetch stage consumes trap_vector/mepc_out.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- MSTATUS_RST, 'h1800, reset value of mstatus (MPP=11).
- MTVEC_RST, 0, reset value of mtvec.
- HART_ID, 0, constant returned by mhartid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata  in  XLEN  operand for write/set/clear.
- csr_rdata  out  XLEN  combinational read of addressed CSR (pre-update value).
- csr_illegal  out  1  csr_op!=0 to an unimplemented or read-only-written address.
- trap_valid  in  1  take trap this cycle.
- trap_pc  in  XLEN  PC of trapping instruction.
- trap_cause  in  XLEN  cause; MSB = interrupt.
- mret  in  1  execute MRET this cycle.
- instret_inc  in  1  one instruction retired.
- irq_ext  in  1  machine external interrupt line (level).
- irq_pending  out  1  interrupt should be taken.
- trap_vector  out  XLEN  trap target PC.
- mepc_out  out  XLEN  current mepc.

Behaviour:
- Implemented CSRs and addresses:
  - mstatus 300: MIE bit3, MPIE bit7, MPP bits12:11; other bits read 0.
  - misa 301: read-only constant; writes ignored, not illegal.
  - mie 304: only MEIE bit11 writable.
  - mtvec 305.
  - mscratch 340.
  - mepc 341: bits[1:0] forced 0.
  - mcause 342.
  - mip 344: MEIP bit11, read-only; writes ignored.
  - mhartid F14: read-only; any write is illegal.
- Write data by op:
  - write: new = wdata.
  - set: new = old | wdata.
  - clear: new = old & ~wdata.
  - csr_op=00: no update, never illegal.
- csr_illegal: combinational, same cycle. An illegal op updates nothing.
- Update priority each cycle: rst > trap_valid > mret > CSR op. The lower-priority actions in that cycle are dropped.
- Trap entry (one cycle, visible next cycle):
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - MPIE <= MIE; MIE <= 0; MPP <= 11.
- mret: MIE <= MPIE; MPIE <= 1; MPP <= 11.
- trap_vector, from mtvec[1:0]:
  - 00: {mtvec[XLEN-1:2],2'b00}.
  - 01 and trap_cause MSB=1: base + 4*trap_cause[XLEN-2:0].
  - all other cases: base.
  - Combinational on the current mtvec and trap_cause.
- mip.MEIP = irq_ext registered, so one cycle latency.
- irq_pending = MIE & MEIE & MEIP, combinational from registers.
- Reset values:
  - mstatus = MSTATUS_RST.
  - mtvec = MTVEC_RST.
  - mie, mip, mscratch, mepc, mcause, counters = 0.
  - Reset mid-trap discards the trap.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - mcycle B00 (and mcycleh B80 when XLEN=32) and minstret B02 (and minstreth B82 when XLEN=32) are implemented; each counter is 64 bits.
  - mcycle increments every non-reset cycle; minstret increments when instret_inc=1.
  - The 64-bit counter wraps to 0 after all-ones.
  - A CSR write to a counter half in the same cycle overrides that cycle's increment for the whole counter: the written half takes the new value, the other half holds.
  - When XLEN=64, B80/B82 are illegal.
- Undefined: all counter addresses are illegal and read 0; no counter flops are synthesised.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - csr_op encoding.
  - mstatus/mie/mip bit-index constants.
  - misa constant.
- One natural sub-module, csr_counter64: a 64-bit counter with increment enable, 32-bit half write-enables and a full-width write. It is instantiated twice under CSR_COUNTERS_EN.

Test Plan:
1. Reset, then read 300 -> rdata='h1800. Read 305 -> 0. csr_illegal=0 with op=00.
2. Write 305='h8000_0001, then trap_valid with cause='h8000_000B -> trap_vector='h8000_002C. With cause=2 -> 'h8000_0000.
3. Set mstatus bit3, then trap with pc='h8000_0102 -> next cycle mepc='h8000_0100, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
4. MIE=1, MEIE=1, irq_ext rises at cycle N -> irq_pending=1 at N+1. Clear mie bit11 -> irq_pending=0 next cycle.
5. Same cycle trap_valid=1 and csr write mscratch='h55 -> mscratch unchanged, trap applied. Write to F14 -> csr_illegal=1, no state change.
6. CSR_COUNTERS_EN, XLEN=32: write mcycle='hFFFF_FFFF, next cycle mcycleh=1, mcycle=0. Write B00=5 during an increment -> reads 5, then 6.
